// File: rtl/mc_unified_mem.sv
// Unified instruction/data memory for the multicycle MIPS core, with an instruction
// register, a boot-load stream that holds the core in reset, and a sticky access-fault flag.
module mc_unified_mem #(
    parameter int DEPTH     = 64,
    parameter bit SKIP_BOOT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic        iord,
    input  logic        memwrite,
    input  logic        irwrite,
    output logic [31:0] readdata,
    output logic [31:0] instr,
    input  logic        boot_valid,
    input  logic [31:0] boot_data,
    input  logic        boot_last,
    output logic        boot_ready,
    output logic        cpu_rst,
    output logic        fault
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   addr;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          aligned;
    logic          pc_ok;
    logic          boot_accept;
    logic          cpu_store;
    logic          store_fault;
    logic          fetch_fault;
    logic          ir_load;

    assign addr     = iord ? aluout : pc;
    assign idx      = addr[AW+1:2];
    assign in_range = (addr[31:AW+2] == '0);
    assign aligned  = (addr[1:0] == 2'b00);
    assign pc_ok    = (pc[31:AW+2] == '0) && (pc[1:0] == 2'b00);

    // Out-of-range reads return zero rather than an aliased word.
    assign readdata = in_range ? mem[idx] : '0;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        cpu_rst     = 1'b0;
        boot_ready  = 1'b0;
        boot_accept = 1'b0;
        cpu_store   = 1'b0;
        store_fault = 1'b0;
        fetch_fault = 1'b0;
        ir_load     = 1'b0;
        case (state)
            LOAD: begin
                cpu_rst     = 1'b1;
                boot_ready  = 1'b1;
                boot_accept = boot_valid;
                if (boot_valid && (boot_last || ptr == AW'(DEPTH - 1)))
                    state_next = RUN;
            end
            RUN: begin
                cpu_store   = memwrite && in_range && aligned;
                store_fault = memwrite && !(in_range && aligned);
                fetch_fault = irwrite && !pc_ok;
                ir_load     = irwrite;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SKIP_BOOT ? RUN : LOAD;
            ptr   <= '0;
            instr <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            // The final-word transition to RUN makes an increment at DEPTH-1 unnecessary.
            if (boot_accept && ptr != AW'(DEPTH - 1))
                ptr <= ptr + AW'(1);
            if (ir_load)
                instr <= readdata;
            if (store_fault || fetch_fault)
                fault <= 1'b1;
        end
    end

    // NOTE: the memory array is deliberately not reset; contents survive reset and a plain RAM can be inferred.
    always_ff @(posedge clk) begin
        if (boot_accept)
            mem[ptr] <= boot_data;
        else if (cpu_store)
            mem[idx] <= writedata;
    end

endmodule

// File: doc/mc_unified_mem.md
Name: mc_unified_mem

Overview:
- Memory-side responder for the multicycle MIPS core: a single unified instruction/data memory.
- The core drives pc, aluout, writedata, iord, memwrite and irwrite. This block returns readdata and holds the instruction register that feeds the core's instr input.
- A boot-load FSM fills memory from a valid/ready word stream while the core is held in reset through cpu_rst.
- Bad CPU accesses raise a sticky fault flag.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..4096; word index = addr[log2(DEPTH)+1:2].
- SKIP_BOOT, 0, 1 = leave reset directly in RUN with no boot load.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  CPU instruction-fetch byte address.
- aluout  in  32  CPU data byte address; used when iord=1.
- writedata  in  32  CPU store data.
- iord  in  1  address select: 0 = pc, 1 = aluout.
- memwrite  in  1  CPU store strobe.
- irwrite  in  1  instruction-register load strobe.
- readdata  out  32  combinational read of the selected address.
- instr  out  32  instruction register, to the core's instr input.
- boot_valid  in  1  boot word present.
- boot_data  in  32  boot word.
- boot_last  in  1  marks the final boot word; qualified by boot_valid.
- boot_ready  out  1  boot word accepted this cycle when boot_valid is also high.
- cpu_rst  out  1  holds the core in reset.
- fault  out  1  sticky access-fault flag.

Behaviour:
- States: LOAD and RUN. The state register is one bit.
- On reset:
  - state = RUN if SKIP_BOOT, else LOAD.
  - boot pointer = 0, instr = 0, fault = 0.
  - Memory contents are NOT cleared.
  - Reset mid-load restarts the pointer at 0; words already written are retained.
- Output decode from state:
  - cpu_rst = (state==LOAD).
  - boot_ready = (state==LOAD).
  - Both are decoded from the state register with no combinational path from inputs.
  - During reset both outputs follow the reset state value.
- LOAD state:
  - On boot_valid & boot_ready: mem[ptr] <= boot_data, ptr <= ptr+1.
  - Go to RUN if boot_last=1, or if ptr==DEPTH-1. The pointer never wraps.
  - The first RUN cycle (cpu_rst=0) is the cycle after the edge that accepted the final word.
  - memwrite and irwrite are ignored in LOAD, and no fault is logged.
- RUN state:
  - boot_ready=0; boot inputs are ignored.
  - There is no return to LOAD except through reset.
- Address and read path:
  - addr = iord ? aluout : pc.
  - readdata = mem[addr index] combinationally, in any state.
  - readdata = 0 when addr >= 4*DEPTH (out of range).
  - Low two address bits are ignored for reads.
- Store (RUN only):
  - On memwrite, mem[index] <= writedata at the edge.
  - Read-before-write: readdata shows the old value until the edge and the new value after it.
- Fault (RUN only):
  - Condition: memwrite with addr[1:0]!=0, or memwrite with addr out of range. The write is suppressed.
  - Also a fault: irwrite with pc out of range or pc[1:0]!=0. instr still loads the readdata value, which is 0 when out of range.
  - fault sets at the edge and stays 1 until reset.
- Instruction register:
  - On irwrite in RUN: instr <= readdata at the edge; otherwise instr holds.
  - If memwrite and irwrite are both asserted in the same cycle, instr captures the pre-write value.
- Latency:
  - Reads: 0 cycles.
  - instr update and writes: 1 edge.
  - Boot: one word per cycle at full throughput.

Test Plan:
- Boot, DEPTH=64, SKIP_BOOT=0: reset, then stream 0x20080005, 0x20090007, 0x01095020 with boot_last on word 3 -> boot_ready=1 and cpu_rst=1 for 3 accept cycles; cpu_rst=0 on the next cycle; with iord=0, pc=8: readdata=0x01095020.
- IR load: RUN, pc=4, irwrite=1 for one cycle -> instr=0x20090007 after the edge; irwrite=0 with pc=0 -> instr unchanged.
- Store and read-back: iord=1, aluout=0x10, writedata=0xDEADBEEF, memwrite=1 -> readdata=0xDEADBEEF after the edge; pc=0x10 with irwrite -> instr=0xDEADBEEF. Same-cycle memwrite+irwrite at 0x14 (old 0) -> instr=0, memory=new value.
- Faults: memwrite to aluout=0x12 -> fault=1, word at 0x10 unchanged. After reset, memwrite to aluout=0x100 (DEPTH=64) -> fault=1, readdata=0. Fault stays set across later good accesses.
- Boot overflow and mid-load reset: 64 words without boot_last -> RUN after the 64th word, boot_ready=0. Separately, reset after 2 words, then reload -> pointer restarts at 0.
- SKIP_BOOT=1: after reset, cpu_rst=0, boot_ready=0; boot_valid=1 has no effect on memory.
